// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: access size codes and FSM state encoding shared by the load/store unit
package load_store_unit_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;
endpackage

// File: rtl/load_store_unit_align.sv
// load_store_unit_align: big-endian sub-word extraction/extension for loads and lane merging for stores
module load_store_unit_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsign,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] raw;
  logic [31:0] mask;
  // lane 0 is the most significant one, so the shift counts down from the top of the word
  always_comb begin
    sh     = size == SIZE_HALF ? {~offset[1], 4'b0000} : {~offset, 3'b000};
    raw    = word >> sh;
    mask   = (size == SIZE_HALF ? 32'h0000_ffff : 32'h0000_00ff) << sh;
    rdata  = size == SIZE_BYTE ? {{24{~unsign & raw[7]}}, raw[7:0]} :
             size == SIZE_HALF ? {{16{~unsign & raw[15]}}, raw[15:0]} : word;
    merged = size == SIZE_WORD ? wdata : (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word-only memory with a read-modify-write path
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = 4096,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsign,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_write,
  output logic              mem_read,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t            state, state_nx;
  logic              write_q, unsign_q, bad;
  logic [1:0]        size_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q, merge_word, ext_data, merged;
  assign bad = req_size == SIZE_RSVD || (req_size == SIZE_HALF && req_addr[0]) ||
               (req_size == SIZE_WORD && |req_addr[1:0]) || req_addr >= 32'(MEM_BYTES);
  load_store_unit_align u_align (
    .word   (write_q ? merge_word : mem_rdata),
    .offset (addr_q[1:0]),
    .size   (size_q),
    .unsign (unsign_q),
    .wdata  (wdata_q),
    .rdata  (ext_data),
    .merged (merged)
  );
  // strobes are gated by rst_n so a reset edge never coincides with a memory write
  assign busy      = state != S_IDLE;
  assign done      = state == S_RESP;
  assign mem_read  = state == S_RD && rst_n;
  assign mem_write = state == S_WR && rst_n;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = merged;
  // state register
  always_ff @(posedge clk)
    state <= rst_n ? state_nx : S_IDLE;
  // next state: errors skip memory, word stores skip the read, everything else reads first
  always_comb begin
    state_nx = S_IDLE;
    case (state)
      S_IDLE:  state_nx = !req_valid ? S_IDLE : bad ? S_RESP :
                          (req_write && req_size == SIZE_WORD) ? S_WR : S_RD;
      S_RD:    state_nx = write_q ? S_WR : S_RESP;
      S_WR:    state_nx = S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end
  // request latch, error flag, load result and the read half of the read-modify-write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_q    <= 1'b0;
      unsign_q   <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_word <= '0;
      rdata      <= '0;
      err        <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        write_q  <= req_write;
        unsign_q <= req_unsign;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        err      <= bad;
      end
      if (state == S_RD && !write_q) rdata <= ext_data;
      if (state == S_RD && write_q) merge_word <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a word-only data memory
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsign = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        busy, done, err, mem_write, mem_read;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:1023];
  int          wr_cnt = 0, rd_cnt = 0;
  int          checks = 0, failures = 0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsign(req_unsign), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_read && mem_addr[1:0] == 2'b00 && mem_addr < 32'd4096) ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[11:2]] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read) rd_cnt <= rd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nw, output int nr);
    int w0, r0;
    w0 = wr_cnt;
    r0 = rd_cnt;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsign = u; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = 99;
    rd = rdata;
    er = err;
    nw = wr_cnt - w0;
    nr = rd_cnt - r0;
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, nw, nr, dcnt, rcnt, icnt;
    logic [31:0] rd;
    logic er;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_strobes", {30'h0, mem_write, mem_read}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    access(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, lat, rd, er, nw, nr);
    check("sw_lat", 32'(lat), 2);
    check("sw_writes", 32'(nw), 1);
    access(0, 2'b10, 0, 32'h10, 32'h0, lat, rd, er, nw, nr);
    check("lw_lat", 32'(lat), 2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", 32'(er), 0);

    access(1, 2'b10, 0, 32'h20, 32'h11223344, lat, rd, er, nw, nr);
    access(1, 2'b00, 0, 32'h21, 32'h000000AA, lat, rd, er, nw, nr);
    check("sb_lat", 32'(lat), 3);
    check("sb_writes", 32'(nw), 1);
    check("sb_word", mem[8], 32'h11AA3344);
    access(1, 2'b01, 0, 32'h22, 32'h0000BEEF, lat, rd, er, nw, nr);
    check("sh_lat", 32'(lat), 3);
    check("sh_writes", 32'(nw), 1);
    check("sh_word", mem[8], 32'h11AABEEF);
    access(0, 2'b10, 0, 32'h20, 32'h0, lat, rd, er, nw, nr);
    check("lw_merged", rd, 32'h11AABEEF);

    access(1, 2'b10, 0, 32'h30, 32'h80FF7F01, lat, rd, er, nw, nr);
    access(0, 2'b00, 0, 32'h30, 32'h0, lat, rd, er, nw, nr);
    check("lb_30", rd, 32'hFFFFFF80);
    access(0, 2'b00, 1, 32'h30, 32'h0, lat, rd, er, nw, nr);
    check("lbu_30", rd, 32'h00000080);
    access(0, 2'b00, 0, 32'h33, 32'h0, lat, rd, er, nw, nr);
    check("lb_33", rd, 32'h00000001);
    access(0, 2'b01, 0, 32'h32, 32'h0, lat, rd, er, nw, nr);
    check("lh_32", rd, 32'h00007F01);
    access(0, 2'b01, 0, 32'h30, 32'h0, lat, rd, er, nw, nr);
    check("lh_30", rd, 32'hFFFF80FF);
    check("lh_30_lat", 32'(lat), 2);

    access(0, 2'b10, 0, 32'h12, 32'h0, lat, rd, er, nw, nr);
    check("lw_mis_err", 32'(er), 1);
    check("lw_mis_lat", 32'(lat), 1);
    check("lw_mis_mem", 32'(nw + nr), 0);
    check("lw_mis_rdata", rd, 32'hFFFF80FF);
    access(1, 2'b01, 0, 32'h31, 32'h1234, lat, rd, er, nw, nr);
    check("sh_mis_err", 32'(er), 1);
    check("sh_mis_lat", 32'(lat), 1);
    check("sh_mis_mem", 32'(nw + nr), 0);
    access(0, 2'b11, 0, 32'h30, 32'h0, lat, rd, er, nw, nr);
    check("rsvd_err", 32'(er), 1);
    check("rsvd_lat", 32'(lat), 1);
    check("rsvd_mem", 32'(nw + nr), 0);
    access(0, 2'b10, 0, 32'h1000, 32'h0, lat, rd, er, nw, nr);
    check("range_err", 32'(er), 1);
    check("range_lat", 32'(lat), 1);
    check("range_mem", 32'(nw + nr), 0);
    check("range_rdata", rd, 32'hFFFF80FF);
    access(0, 2'b00, 1, 32'h31, 32'h0, lat, rd, er, nw, nr);
    check("err_cleared", 32'(er), 0);
    check("lbu_31", rd, 32'h000000FF);

    access(1, 2'b10, 0, 32'h40, 32'h12345678, lat, rd, er, nw, nr);
    nw = wr_cnt;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsign = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h000000AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rmw_in_wr", 32'(mem_write), 1);
    rst_n = 1'b0;
    #1;
    check("rmw_rst_gate", 32'(mem_write), 0);
    @(posedge clk); #1;
    check("rmw_rst_outs", {busy, done, err, mem_write, mem_read}, 0);
    check("rmw_rst_rdata", rdata, 0);
    check("rmw_rst_addr", mem_addr, 0);
    check("rmw_rst_wdata", mem_wdata, 0);
    check("rmw_no_write", 32'(wr_cnt - nw), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(0, 2'b10, 0, 32'h40, 32'h0, lat, rd, er, nw, nr);
    check("rmw_word_kept", rd, 32'h12345678);

    dcnt = 0; rcnt = 0; icnt = 0;
    nr = rd_cnt;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsign = 1'b0; req_addr = 32'h10;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      dcnt += int'(done);
      rcnt += int'(mem_read);
      icnt += int'(!busy);
    end
    req_valid = 1'b0;
    check("b2b_done", 32'(dcnt), 3);
    check("b2b_reads", 32'(rcnt), 3);
    check("b2b_idle", 32'(icnt), 3);
    check("b2b_rdata", rdata, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("b2b_read_cycles", 32'(rd_cnt - nr), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
